// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and FSM state type for the iterative AES-128 block.
//   BLOCK_W   - data/key block width
//   KEY_IDX_W - width of the round-key index (and round counter)
//   NR_AES128 - rounds after the initial AddRoundKey for AES-128
package aes_pkg;

    localparam int unsigned BLOCK_W   = 128;
    localparam int unsigned KEY_IDX_W = 4;
    localparam int unsigned NR_AES128 = 10;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/aes_round_cnt.sv
// aes_round_cnt: round counter r (1..NR) plus per-round wait counter (0..DP_LAT).
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   load        - restart at round 1, wait 0 (block accepted)
//   en          - advance while a round is in progress
//   round       - current round number r
//   round_done  - final cycle of the current round (wait == DP_LAT)
//   last_round  - r == NR
module aes_round_cnt
    import aes_pkg::*;
#(
    parameter int unsigned NR     = NR_AES128,
    parameter int unsigned DP_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 en,
    output logic [KEY_IDX_W-1:0] round,
    output logic                 round_done,
    output logic                 last_round
);

    // Wait counter is at least one bit even for a combinational datapath.
    localparam int unsigned            WAIT_W   = (DP_LAT > 0) ? $clog2(DP_LAT + 1) : 1;
    localparam logic [WAIT_W-1:0]      WAIT_MAX = WAIT_W'(DP_LAT);
    localparam logic [KEY_IDX_W-1:0]   R_LAST   = KEY_IDX_W'(NR);

    logic [WAIT_W-1:0]    wait_q;
    logic [KEY_IDX_W-1:0] round_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_q <= KEY_IDX_W'(1);
            wait_q  <= '0;
        end else if (load) begin
            round_q <= KEY_IDX_W'(1);
            wait_q  <= '0;
        end else if (en) begin
            if (round_done) begin
                wait_q <= '0;
                // r parks at NR on the last round; the next accept reloads it.
                if (!last_round) begin
                    round_q <= round_q + KEY_IDX_W'(1);
                end
            end else begin
                wait_q <= wait_q + WAIT_W'(1);
            end
        end
    end

    assign round      = round_q;
    assign round_done = (wait_q == WAIT_MAX);
    assign last_round = (round_q == R_LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences one 128-bit block through iterative AES-128 using a
// shared round datapath and an external combinational round-key store.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   in_valid/in_ready      - plaintext handshake, in_block = plaintext
//   out_valid/out_ready    - ciphertext handshake, out_block = ciphertext
//   busy                   - block in flight
//   key_idx / key_in       - round-key request and same-cycle key
//   dp_block/dp_key        - datapath state and round key
//   dp_final               - last round (datapath skips MixColumns)
//   dp_result              - datapath output, valid DP_LAT edges after stable inputs
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR     = NR_AES128,
    parameter int unsigned DP_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLOCK_W-1:0]   in_block,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLOCK_W-1:0]   out_block,
    output logic                 busy,
    output logic [KEY_IDX_W-1:0] key_idx,
    input  logic [BLOCK_W-1:0]   key_in,
    output logic [BLOCK_W-1:0]   dp_block,
    output logic [BLOCK_W-1:0]   dp_key,
    output logic                 dp_final,
    input  logic [BLOCK_W-1:0]   dp_result
);

    if (NR == 0 || NR > 15) begin : g_bad_nr
        $error("aes_round_ctrl: NR must lie in 1..15");
    end

    ctrl_state_t          state_q;
    ctrl_state_t          state_d;
    logic [BLOCK_W-1:0]   blk_q;
    logic [KEY_IDX_W-1:0] round;
    logic                 round_done;
    logic                 last_round;
    logic                 accept;

    assign accept = (state_q == IDLE) && in_valid;

    aes_round_cnt #(
        .NR     (NR),
        .DP_LAT (DP_LAT)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .en         (state_q == ROUND),
        .round      (round),
        .round_done (round_done),
        .last_round (last_round)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Initial AddRoundKey happens on accept; key_idx is 0 in IDLE so key_in is round key 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_q <= '0;
        end else if (accept) begin
            blk_q <= in_block ^ key_in;
        end else if ((state_q == ROUND) && round_done) begin
            blk_q <= dp_result;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)                  state_d = ROUND;
            ROUND:   if (round_done && last_round)  state_d = DONE;
            DONE:    if (out_ready)                 state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        key_idx   = '0;
        dp_final  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ROUND: begin
                key_idx  = round;
                dp_final = last_round;
            end
            DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign out_block = blk_q;
    assign dp_block  = blk_q;
    assign dp_key    = key_in;

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

    localparam int NR = 10;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_block  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_block [3];
    logic         busy      [3];
    logic [3:0]   key_idx   [3];
    logic [127:0] key_in    [3];
    logic [127:0] dp_block  [3];
    logic [127:0] dp_key    [3];
    logic         dp_final  [3];
    logic [127:0] dp_result [3];

    logic [127:0] rk [0:15];

    int n_vec;
    int n_err;

    // ---------------- AES software model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from GF(2^8) inverse (a^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        logic [7:0] e;
        v = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            v = gmul(v, v);
            if (e[i]) v = gmul(v, a);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   m [16];
        logic [127:0] o;
        for (int j = 0; j < 16; j++) b[j] = s[127-8*j -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = sbox(b[r+4*((c+r)%4)]);
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
            m[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
            m[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
            m[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end
        for (int j = 0; j < 16; j++) o[127-8*j -: 8] = fin ? t[j] : m[j];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) s = aes_round(s, rk[r], r == NR);
        return s;
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- DUTs: DP_LAT = 0, 1, 2 ----------------
    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_round_ctrl #(
            .NR     (NR),
            .DP_LAT (g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_block  (in_block[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_block (out_block[g]),
            .busy      (busy[g]),
            .key_idx   (key_idx[g]),
            .key_in    (key_in[g]),
            .dp_block  (dp_block[g]),
            .dp_key    (dp_key[g]),
            .dp_final  (dp_final[g]),
            .dp_result (dp_result[g])
        );

        assign key_in[g] = rk[key_idx[g]];

        if (g == 0) begin : g_comb
            assign dp_result[g] = aes_round(dp_block[g], dp_key[g], dp_final[g]);
        end else begin : g_pipe
            logic [127:0] st [g];
            always_ff @(posedge clk) begin
                st[0] <= aes_round(dp_block[g], dp_key[g], dp_final[g]);
                for (int i = 1; i < g; i++) st[i] <= st[i-1];
            end
            assign dp_result[g] = st[g-1];
        end
    end

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block through instance d; checks latency, ciphertext and return to IDLE.
    task automatic run_block(input int d, input logic [127:0] pt, input logic [127:0] exp_ct,
                             input string nm);
        int lat;
        n_vec++;
        if (in_ready[d] !== 1'b1) begin
            n_err++;
            $display("FAIL %s_in_ready d=%0d got %b want 1", nm, d, in_ready[d]);
        end
        in_valid[d] = 1'b1;
        in_block[d] = pt;
        tick();
        in_valid[d] = 1'b0;
        in_block[d] = '0;
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        n_vec++;
        if (lat != NR * (d + 1)) begin
            n_err++;
            $display("FAIL %s_latency d=%0d got %0d want %0d", nm, d, lat, NR * (d + 1));
        end
        n_vec++;
        if (out_block[d] !== exp_ct) begin
            n_err++;
            $display("FAIL %s_ct d=%0d got %h want %h", nm, d, out_block[d], exp_ct);
        end
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        n_vec++;
        if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
            n_err++;
            $display("FAIL %s_release d=%0d got out_valid=%b in_ready=%b want 0 1",
                     nm, d, out_valid[d], in_ready[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_flags d=%0d got in_ready=%b out_valid=%b busy=%b want 1 0 0",
                         d, in_ready[d], out_valid[d], busy[d]);
            end
            n_vec++;
            if (key_idx[d] !== 4'd0 || dp_final[d] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_key d=%0d got key_idx=%0d dp_final=%b want 0 0",
                         d, key_idx[d], dp_final[d]);
            end
            n_vec++;
            if (out_block[d] !== 128'h0) begin
                n_err++;
                $display("FAIL reset_state d=%0d got %h want 0", d, out_block[d]);
            end
        end
    endtask

    task automatic test_fips_b();
        set_key(KEY_B);
        run_block(1, PT_B, CT_B, "fips_b");
    endtask

    task automatic test_fips_c1();
        set_key(KEY_C);
        for (int d = 0; d < 3; d++) run_block(d, PT_C, CT_C, "fips_c1");
    endtask

    task automatic test_sequence();
        logic [127:0] s;
        int r;
        set_key(KEY_C);
        s = PT_C ^ rk[0];
        n_vec++;
        if (key_idx[1] !== 4'd0) begin
            n_err++;
            $display("FAIL seq_idle_key got %0d want 0", key_idx[1]);
        end
        in_valid[1] = 1'b1;
        in_block[1] = PT_C;
        tick();
        in_valid[1] = 1'b0;
        for (int k = 0; k < 2 * NR; k++) begin
            r = 1 + k / 2;
            n_vec++;
            if (key_idx[1] !== 4'(r)) begin
                n_err++;
                $display("FAIL seq_key_idx cyc=%0d got %0d want %0d", k, key_idx[1], r);
            end
            n_vec++;
            if (dp_final[1] !== (r == NR)) begin
                n_err++;
                $display("FAIL seq_dp_final cyc=%0d got %b want %b", k, dp_final[1], r == NR);
            end
            n_vec++;
            if (dp_block[1] !== s) begin
                n_err++;
                $display("FAIL seq_dp_block cyc=%0d got %h want %h", k, dp_block[1], s);
            end
            if (k % 2 == 1) s = aes_round(s, rk[r], r == NR);
            tick();
        end
        n_vec++;
        if (out_valid[1] !== 1'b1 || out_block[1] !== CT_C) begin
            n_err++;
            $display("FAIL seq_out got valid=%b ct=%h want 1 %h", out_valid[1], out_block[1], CT_C);
        end
        out_ready[1] = 1'b1;
        tick();
        out_ready[1] = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        set_key(KEY_B);
        in_valid[1] = 1'b1;
        in_block[1] = PT_B;
        tick();
        in_valid[1] = 1'b0;
        lat = 0;
        while (out_valid[1] !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        n_vec++;
        if (lat != 2 * NR) begin
            n_err++;
            $display("FAIL bp_latency got %0d want %0d", lat, 2 * NR);
        end
        // Offer a second block while stalled; it must not be taken.
        in_valid[1] = 1'b1;
        in_block[1] = PT_C;
        for (int i = 0; i < 7; i++) begin
            n_vec++;
            if (out_valid[1] !== 1'b1 || out_block[1] !== CT_B || in_ready[1] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_stall cyc=%0d got valid=%b ct=%h in_ready=%b want 1 %h 0",
                         i, out_valid[1], out_block[1], in_ready[1], CT_B);
            end
            tick();
        end
        out_ready[1] = 1'b1;
        tick();
        n_vec++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_handshake got valid=%b in_ready=%b busy=%b want 0 1 0",
                     out_valid[1], in_ready[1], busy[1]);
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;
        tick();
        n_vec++;
        if (busy[1] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_no_accept got busy=%b want 0", busy[1]);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        set_key(KEY_C);
        in_valid[1] = 1'b1;
        in_block[1] = PT_C;
        tick();
        in_valid[1] = 1'b0;
        cnt = 0;
        while (key_idx[1] !== 4'd5 && cnt < 100) begin
            tick();
            cnt++;
        end
        n_vec++;
        if (key_idx[1] !== 4'd5) begin
            n_err++;
            $display("FAIL rstmid_reach_round got %0d want 5", key_idx[1]);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (busy[1] !== 1'b0 || out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || key_idx[1] !== 4'd0) begin
            n_err++;
            $display("FAIL rstmid_async got busy=%b out_valid=%b in_ready=%b key_idx=%0d want 0 0 1 0",
                     busy[1], out_valid[1], in_ready[1], key_idx[1]);
        end
        @(negedge clk) rst = 1'b0;
        run_block(1, PT_C, CT_C, "post_rst");
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [4];
        logic [127:0] cts [4];
        int           acc_cyc [4];
        int           n_acc;
        int           n_out;
        int           cyc;
        logic         acc;
        set_key({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 4; i++) begin
            pts[i] = {$urandom, $urandom, $urandom, $urandom};
            cts[i] = aes_encrypt(pts[i]);
            acc_cyc[i] = 0;
        end
        n_acc = 0;
        n_out = 0;
        cyc   = 0;
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        in_block[1]  = pts[0];
        while (n_out < 4 && cyc < 400) begin
            acc = in_valid[1] & in_ready[1];
            tick();
            cyc++;
            if (acc) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 4) in_block[1] = pts[n_acc];
                else           in_valid[1] = 1'b0;
            end
            if (out_valid[1] === 1'b1) begin
                n_vec++;
                if (out_block[1] !== cts[n_out]) begin
                    n_err++;
                    $display("FAIL b2b_ct blk=%0d got %h want %h", n_out, out_block[1], cts[n_out]);
                end
                n_out++;
            end
        end
        tick();
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;
        n_vec++;
        if (n_out != 4) begin
            n_err++;
            $display("FAIL b2b_outputs got %0d want 4", n_out);
        end
        for (int i = 1; i < 4; i++) begin
            n_vec++;
            if (n_acc <= i || acc_cyc[i] - acc_cyc[i-1] != 2 * NR + 2) begin
                n_err++;
                $display("FAIL b2b_spacing pair=%0d got %0d want %0d", i,
                         (n_acc > i) ? acc_cyc[i] - acc_cyc[i-1] : -1, 2 * NR + 2);
            end
        end
        n_vec++;
        if (in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle got in_ready=%b busy=%b want 1 0", in_ready[1], busy[1]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        clk   = 1'b0;
        rst   = 1'b0;
        n_vec = 0;
        n_err = 0;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_block[d]  = '0;
            out_ready[d] = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        test_reset();
        @(negedge clk) rst = 1'b0;
        tick();
        test_fips_b();
        test_fips_c1();
        test_sequence();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences one 128-bit block through an iterative AES-128 encryption using a single shared round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey) plus an external round-key store.
- Performs the initial AddRoundKey itself, then issues NR rounds to the datapath, suppressing MixColumns on the last round.
- Sits between the block-level valid/ready interface and the round datapath.

Parameters:
- NR, 10, number of rounds after the initial AddRoundKey (AES-128).
- DP_LAT, 1, register stages in the round datapath (0 = combinational).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  plaintext valid
- in_ready  output  1  controller can accept a block
- in_block  input  128  plaintext
- out_valid  output  1  ciphertext valid
- out_ready  input  1  downstream accepts ciphertext
- out_block  output  128  ciphertext
- busy  output  1  block in flight (not IDLE)
- key_idx  output  4  round-key index requested (0..NR)
- key_in  input  128  round key for key_idx, combinational, same cycle
- dp_block  output  128  datapath state input
- dp_key  output  128  datapath round key (= key_in)
- dp_final  output  1  last round, datapath bypasses MixColumns
- dp_result  input  128  datapath output, valid DP_LAT edges after inputs are stable

Behaviour:
- Reset (async, immediate): state=IDLE, round counter=1, wait counter=0, state register=0, in_ready=1, out_valid=0, busy=0, dp_final=0, key_idx=0. Reset mid-block aborts the block silently; nothing is emitted.
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, key_idx=0.
  - On in_valid&in_ready: state_reg <= in_block ^ key_in, round counter r <= 1, wait counter <= 0, go to ROUND.
- ROUND:
  - key_idx=r, dp_block=state_reg, dp_key=key_in, dp_final=(r==NR). All held stable for the whole round.
  - Wait counter counts 0..DP_LAT.
  - On the edge where wait counter==DP_LAT: state_reg <= dp_result and wait counter <= 0.
    - If r==NR, go to DONE.
    - Otherwise r <= r+1.
  - Each round takes exactly DP_LAT+1 cycles.
- DONE:
  - out_valid=1, out_block=state_reg, both held until out_ready.
  - On out_valid&out_ready: go to IDLE.
  - No same-cycle accept: in_ready rises the cycle after the output handshake.
- Latency: out_valid asserts NR*(DP_LAT+1) cycles after the accept edge. Defaults give 20 cycles. Throughput is one block per NR*(DP_LAT+1)+2 cycles minimum.
- in_valid while busy is ignored; in_block is not sampled. in_ready=0 outside IDLE.
- out_ready while not DONE has no effect.
- out_block equals state_reg in all states, but is only meaningful when out_valid=1.
- Width: r is 4 bits. NR must lie in 1..15 (elaboration check). Wait counter is clog2(DP_LAT+1) bits, minimum 1.
- dp_key and the key_idx→key_in path are combinational. The key store must not register key_in.

Decomposition:
- Shared package aes_pkg holds: BLOCK_W=128, KEY_IDX_W=4, NR_AES128=10, and the FSM state enum {IDLE, ROUND, DONE}.
- One natural sub-module: aes_round_cnt, the round/wait counter pair with round_done and last_round outputs. The FSM and state register stay in aes_round_ctrl.
- Bench: the codebase round datapath wrapped to DP_LAT stages, plus a precomputed key-schedule ROM indexed by key_idx.

Test Plan:
- FIPS-197 App. B, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_block 3925841d02dc09fbdc118597196a0b32. out_valid exactly 20 cycles after the accept edge.
- FIPS-197 C.1, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. Same checks repeated with DP_LAT=0 (10 cycles) and DP_LAT=2 (30 cycles).
- Backpressure: out_ready held 0 for 7 cycles after out_valid -> out_valid and out_block stable throughout. in_ready=0 until the cycle after the out_ready handshake. A second in_valid during the stall is not accepted.
- Sequencing trace: key_idx steps 0,1..10. dp_final=1 only while key_idx==10. key_idx and dp_block are each constant for DP_LAT+1 cycles per round.
- Reset mid-operation: rst asserted at round 5 -> same cycle (async): busy=0, out_valid=0, in_ready=1. Next block after deassert yields the correct ciphertext with nominal latency.
- Back-to-back: 4 random blocks with in_valid held high and out_ready=1 -> every output matches the software model. Accepts are spaced exactly NR*(DP_LAT+1)+2 cycles apart.
